// File: rtl/ra_defs.sv
// Shared definitions for the return-address stack: default geometry,
// count-width helper and the control opcode used by the push/pop decode.
package ra_defs;

    localparam int RA_N_DEF     = 32;
    localparam int RA_DEPTH_DEF = 8;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int ra_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int RA_CNT_W_DEF = $clog2(RA_DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        RA_OP_NONE = 2'd0,
        RA_OP_PUSH = 2'd1,
        RA_OP_POP  = 2'd2,
        RA_OP_REPL = 2'd3
    } ra_op_e;

    // Push+pop on an empty stack has nothing to replace, so it degrades to
    // a plain push (and therefore never reports underflow).
    function automatic ra_op_e ra_decode(input logic push, input logic pop,
                                         input logic empty);
        if (push && pop && !empty) return RA_OP_REPL;
        if (push)                  return RA_OP_PUSH;
        if (pop)                   return RA_OP_POP;
        return RA_OP_NONE;
    endfunction

endpackage

// File: rtl/ra_stack_mem.sv
// DEPTH x N entry array for the return-address stack: one synchronous
// write port and one asynchronous read port. Contents are never reset.
module ra_stack_mem
    import ra_defs::*;
#(
    parameter int N     = RA_N_DEF,
    parameter int DEPTH = RA_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [N-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [N-1:0]             rdata
);

    logic [N-1:0] mem [DEPTH];

    // Single write port; the array holds data only, so no reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ra_stack.sv
// Return-address stack: calls push the link address, returns pop it, and a
// simultaneous call+return replaces the top entry in place.
// Optional feature macro RA_STACK_OVERFLOW_WRAP_EN: when defined, a push on
// a full stack overwrites the oldest entry (circular); otherwise it is dropped.
// overflow/underflow are registered one-cycle pulses in both builds.
module ra_stack
    import ra_defs::*;
#(
    parameter int N     = RA_N_DEF,
    parameter int DEPTH = RA_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [N-1:0]               push_data,
    output logic [N-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] TP_RST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] TP_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [AW-1:0] tp, tp_nxt;
    logic [CW-1:0] count_nxt;
    logic          ovf_nxt, unf_nxt;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  rdata;
    ra_op_e        op;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign op    = ra_decode(push, pop, empty);

    // Next-state decode for pointer, occupancy, write port and error pulses.
    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        we        = 1'b0;
        waddr     = tp + TP_ONE;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        case (op)
            RA_OP_PUSH: begin
                if (full) begin
                    ovf_nxt = 1'b1;
`ifdef RA_STACK_OVERFLOW_WRAP_EN
                    // Slot tp+1 holds the oldest entry when full; reuse it.
                    tp_nxt = tp + TP_ONE;
                    we     = 1'b1;
`endif
                end else begin
                    tp_nxt    = tp + TP_ONE;
                    count_nxt = count + CNT_ONE;
                    we        = 1'b1;
                end
            end
            RA_OP_POP: begin
                if (empty) begin
                    unf_nxt = 1'b1;
                end else begin
                    tp_nxt    = tp - TP_ONE;
                    count_nxt = count - CNT_ONE;
                end
            end
            RA_OP_REPL: begin
                we    = 1'b1;
                waddr = tp;
            end
            default: ;
        endcase
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp        <= TP_RST;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tp        <= tp_nxt;
            count     <= count_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    ra_stack_mem #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (tp),
        .rdata (rdata)
    );

    // top depends only on registered state, so it clears with count on reset.
    assign top = empty ? '0 : rdata;

endmodule

// File: tb/tb_ra_stack.sv
// Scoreboard bench for ra_stack (N=32, DEPTH=4). The stimulus process
// updates a queue-based stack model and enqueues the expected post-edge
// state; a monitor pops and compares one expectation per clock.
module tb_ra_stack;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          push, pop;
    logic [N-1:0]  push_data;
    logic [N-1:0]  top;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    typedef struct {
        logic [N-1:0] top;
        int           count;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] model[$];
    int           checks   = 0;
    int           failures = 0;

    ra_stack #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".top"},       64'(top),       64'(e.top));
        chk({tag, ".count"},     64'(count),     64'(e.count));
        chk({tag, ".empty"},     64'(empty),     64'(e.empty));
        chk({tag, ".full"},      64'(full),      64'(e.full));
        chk({tag, ".overflow"},  64'(overflow),  64'(e.ovf));
        chk({tag, ".underflow"}, 64'(underflow), 64'(e.unf));
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.top = '0; e.count = 0; e.empty = 1'b1; e.full = 1'b0;
        e.ovf = 1'b0; e.unf = 1'b0;
        return e;
    endfunction

    // Apply one request for the coming edge and record what must follow it.
    task automatic step(input logic pu, input logic po, input logic [N-1:0] d);
        exp_t e;
        @(negedge clk);
        push = pu; pop = po; push_data = d;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (pu && po && model.size() > 0) begin
            model[model.size()-1] = d;
        end else if (pu) begin
            if (model.size() == DEPTH) begin
                e.ovf = 1'b1;
`ifdef RA_STACK_OVERFLOW_WRAP_EN
                void'(model.pop_front());
                model.push_back(d);
`endif
            end else begin
                model.push_back(d);
            end
        end else if (po) begin
            if (model.size() == 0) e.unf = 1'b1;
            else void'(model.pop_back());
        end
        e.count = model.size();
        e.top   = (model.size() > 0) ? model[model.size()-1] : '0;
        e.empty = (model.size() == 0);
        e.full  = (model.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Assert reset between edges and require outputs to clear before any edge.
    task automatic apply_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; push_data = '0;
        #2 reset = 1'b1;
        #1 chk_state("async_reset", reset_exp());
        exp_q.delete();
        model.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one expectation is due shortly after every rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_state("cycle", e);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        #2 chk_state("por_reset", reset_exp());
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Basic LIFO order
        step(1, 0, 32'h100); step(1, 0, 32'h200); step(1, 0, 32'h300);
        step(0, 1, '0); step(0, 1, '0); step(0, 1, '0);

        // Underflow pulse, then push+pop on empty behaves as push
        step(0, 1, '0); idle(1);
        step(1, 1, 32'h44); step(0, 1, '0);

        // Replace
        step(1, 0, 32'h10); step(1, 0, 32'h20); step(1, 1, 32'hAA);
        step(0, 1, '0); step(0, 1, '0); idle(1);

        // Overflow behaviour for the configured build
        for (int i = 1; i <= 4; i++) step(1, 0, N'(i));
        step(1, 0, 32'h5);
        for (int i = 0; i < 5; i++) step(0, 1, '0);
        idle(1);

        // Back-to-back overflow and underflow
        for (int i = 1; i <= 6; i++) step(1, 0, N'(32'h70 + i));
        idle(1);
        for (int i = 0; i < 6; i++) step(0, 1, '0);
        idle(1);

        // Reset in the middle of activity
        step(1, 0, 32'hDEAD); step(1, 0, 32'hBEEF);
        apply_reset();
        idle(1);
        step(1, 0, 32'h1234); step(0, 1, '0);

        // Random traffic
        for (int i = 0; i < 1000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
